// File: rtl/word_mem_pkg.sv
// Shared definitions for the word-to-byte memory controller.
package word_mem_pkg;

  // Number of byte lanes in one host word.
  localparam int BYTES_PER_WORD = 4;

  // Width of the byte-lane index (cnt).
  localparam int LANE_W = 2;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit offset of a byte lane inside a 32-bit word (little-endian).
  function automatic logic [4:0] lane_lsb(input logic [LANE_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/word_mem_ctrl_if.sv
// Host word bus plus the byte-memory port of the word memory controller.
// The master side is the host together with the byte memory; the slave
// side is the controller itself.
interface word_mem_ctrl_if #(
  parameter int ADR_W = 8
);

  logic             req;
  logic             we;
  logic [ADR_W-3:0] wadr;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             ready;
  logic             done;
  logic [31:0]      rdata;

  logic             memwr;
  logic [ADR_W-1:0] adr;
  logic [7:0]       wrdata;
  logic [7:0]       memdata;

  modport master (
    output req, we, wadr, wdata, be, memdata,
    input  ready, done, rdata, memwr, adr, wrdata
  );

  modport slave (
    input  req, we, wadr, wdata, be, memdata,
    output ready, done, rdata, memwr, adr, wrdata
  );

endinterface

// File: rtl/word_mem_ctrl.sv
// Word memory controller: turns one 32-bit host read or write into four
// consecutive byte accesses on an 8-bit combinational memory, lane 0 first.
module word_mem_ctrl
  import word_mem_pkg::*;
#(
  parameter int ADR_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  word_mem_ctrl_if.slave bus
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  state_e            state_q, state_d;
  logic [LANE_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADR_W-3:0]  wadr_q, wadr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;

  // Next-state logic: accept in IDLE, walk the four lanes in XFER, pulse DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          wadr_d  = bus.wadr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          cnt_d   = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (!we_q) begin
          rdata_d[lane_lsb(cnt_q) +: 8] = bus.memdata;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_LANE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs; the memory port is only driven while a lane is in flight.
  always_comb begin
    bus.ready  = (state_q == IDLE);
    bus.done   = (state_q == DONE);
    bus.rdata  = rdata_q;
    bus.memwr  = 1'b0;
    bus.adr    = '0;
    bus.wrdata = '0;
    if (state_q == XFER) begin
      bus.adr    = {wadr_q, cnt_q};
      bus.wrdata = wdata_q[lane_lsb(cnt_q) +: 8];
      bus.memwr  = we_q & be_q[cnt_q];
    end
  end

endmodule

// File: tb/tb_word_mem_ctrl.sv
// Self-checking bench for word_mem_ctrl: byte memory, behavioural model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_word_mem_ctrl;

  localparam int ADR_W = 8;
  localparam int MEM_SZ = 1 << ADR_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  word_mem_ctrl_if #(.ADR_W(ADR_W)) bus();

  word_mem_ctrl #(.ADR_W(ADR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Byte memory seen by the DUT, with a side door for preloading words.
  logic [7:0]       mem [MEM_SZ] = '{default: 8'h00};
  logic             pl_en = 1'b0;
  logic [ADR_W-3:0] pl_wadr = '0;
  logic [31:0]      pl_word = '0;

  assign bus.memdata = mem[bus.adr];

  // Memory writes from the DUT strobe or from the preload path.
  always @(posedge clk) begin
    if (bus.memwr === 1'b1) begin
      mem[bus.adr] <= bus.wrdata;
    end else if (pl_en) begin
      for (int i = 0; i < 4; i++) mem[{pl_wadr, 2'(i)}] <= pl_word[8*i +: 8];
    end
  end

  // Behavioural model: phase 0 idle, 1..4 byte lane phase-1, 5 done.
  logic [7:0]       ref_mem [MEM_SZ] = '{default: 8'h00};
  int               m_phase = 0;
  logic             m_we = 1'b0;
  logic [ADR_W-3:0] m_wadr = '0;
  logic [31:0]      m_wdata = '0;
  logic [3:0]       m_be = '0;
  logic [31:0]      m_rdata = '0;

  function automatic logic [7:0] lane_addr(input logic [ADR_W-3:0] w, input int k);
    return 8'(int'(w) * 4 + k);
  endfunction

  initial forever begin
    int k;
    @(posedge clk);
    k = m_phase - 1;
    if (m_phase >= 1 && m_phase <= 4 && m_we && m_be[k])
      ref_mem[lane_addr(m_wadr, k)] = m_wdata[8*k +: 8];
    if (pl_en)
      for (int i = 0; i < 4; i++) ref_mem[lane_addr(pl_wadr, i)] = pl_word[8*i +: 8];
    if (!reset_n) begin
      m_phase = 0;
      m_rdata = '0;
      m_we = 1'b0;
      m_wadr = '0;
      m_wdata = '0;
      m_be = '0;
    end else if (m_phase == 0) begin
      if (bus.req) begin
        m_we = bus.we;
        m_wadr = bus.wadr;
        m_wdata = bus.wdata;
        m_be = bus.be;
        m_phase = 1;
      end
    end else if (m_phase <= 4) begin
      if (!m_we) m_rdata[8*k +: 8] = ref_mem[lane_addr(m_wadr, k)];
      m_phase = m_phase + 1;
    end else begin
      m_phase = 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    int k;
    logic e_memwr;
    logic [7:0] e_adr, e_wrdata;
    @(negedge clk);
    if (chk_en) begin
      k = m_phase - 1;
      e_memwr = 1'b0;
      e_adr = '0;
      e_wrdata = '0;
      if (m_phase >= 1 && m_phase <= 4) begin
        e_adr = lane_addr(m_wadr, k);
        e_wrdata = m_wdata[8*k +: 8];
        e_memwr = m_we & m_be[k];
      end
      check_output("ready", 32'(bus.ready), 32'(m_phase == 0));
      check_output("done", 32'(bus.done), 32'(m_phase == 5));
      check_output("memwr", 32'(bus.memwr), 32'(e_memwr));
      check_output("adr", 32'(bus.adr), 32'(e_adr));
      check_output("wrdata", 32'(bus.wrdata), 32'(e_wrdata));
      check_output("rdata", bus.rdata, m_rdata);
      check_output("exclusive", 32'((int'(bus.ready) + int'(bus.done) + int'(bus.memwr)) > 1), 32'd0);
    end
  end

  task automatic preload_word(input logic [ADR_W-3:0] w, input logic [31:0] d);
    pl_wadr = w;
    pl_word = d;
    pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Present a request and return 1 time unit after the edge that accepts it.
  task automatic apply_stimulus(input logic w, input logic [ADR_W-3:0] a,
                                input logic [31:0] d, input logic [3:0] b, input bit hold);
    bit accepted = 1'b0;
    logic rdy;
    bus.req = 1'b1;
    bus.we = w;
    bus.wadr = a;
    bus.wdata = d;
    bus.be = b;
    for (int i = 0; i < 20; i++) begin
      rdy = bus.ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) report_timeout("accept");
    if (!hold) begin
      bus.req = 1'b0;
      bus.we = 1'($urandom);
      bus.wadr = (ADR_W-2)'($urandom);
      bus.wdata = $urandom;
      bus.be = 4'($urandom);
    end
  endtask

  // Return at a negedge where ready is high.
  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) report_timeout("wait_idle");
  endtask

  logic [7:0] s2_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic       s3_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dn;
    int acc_at;
    logic rdy;
    logic [31:0] dval;
    int bad;

    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.wadr = '0;
    bus.wdata = '0;
    bus.be = '0;

    // Reset and reset-value checks.
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst_ready", 32'(bus.ready), 32'd1);
    check_output("rst_done", 32'(bus.done), 32'd0);
    check_output("rst_memwr", 32'(bus.memwr), 32'd0);
    check_output("rst_adr", 32'(bus.adr), 32'd0);
    check_output("rst_wrdata", 32'(bus.wrdata), 32'd0);
    check_output("rst_rdata", bus.rdata, 32'd0);

    // Scenario 1: read of a preloaded word.
    preload_word(6'd3, 32'hDEADBEEF);
    apply_stimulus(1'b0, 6'd3, $urandom, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("s1_adr", 32'(bus.adr), 32'h0C + 32'(k));
      check_output("s1_memwr", 32'(bus.memwr), 32'd0);
    end
    @(negedge clk);
    check_output("s1_done", 32'(bus.done), 32'd1);
    check_output("s1_rdata", bus.rdata, 32'hDEADBEEF);
    wait_idle();

    // Scenario 2: full write, then read back.
    apply_stimulus(1'b1, 6'd5, 32'h11223344, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("s2_memwr", 32'(bus.memwr), 32'd1);
      check_output("s2_wrdata", 32'(bus.wrdata), 32'(s2_exp[k]));
    end
    wait_idle();
    apply_stimulus(1'b0, 6'd5, 32'h0, 4'h0, 1'b0);
    repeat (5) @(negedge clk);
    check_output("s2_rdata", bus.rdata, 32'h11223344);
    wait_idle();

    // Scenario 3: partial write keeps unselected bytes.
    preload_word(6'd7, 32'hAABBCCDD);
    apply_stimulus(1'b1, 6'd7, 32'h00FF00EE, 4'b0101, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("s3_memwr", 32'(bus.memwr), 32'(s3_pat[k]));
    end
    wait_idle();
    apply_stimulus(1'b0, 6'd7, 32'h0, 4'h0, 1'b0);
    repeat (5) @(negedge clk);
    check_output("s3_rdata", bus.rdata, 32'hAAFFCCEE);
    wait_idle();

    // Scenario 4: req held through XFER and DONE is not accepted early.
    apply_stimulus(1'b0, 6'd9, 32'h0, 4'h0, 1'b1);
    dn = 0;
    acc_at = -1;
    for (int i = 1; i <= 12; i++) begin
      rdy = bus.ready;
      dn += int'(bus.done);
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        acc_at = i;
        break;
      end
    end
    bus.req = 1'b0;
    check_output("s4_accept_gap", 32'(acc_at), 32'd6);
    check_output("s4_done_count", 32'(dn), 32'd1);
    wait_idle();

    // Scenario 5: reset during a write aborts after the first byte.
    preload_word(6'd2, 32'hA5A5A5A5);
    apply_stimulus(1'b1, 6'd2, 32'h12345678, 4'b1111, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("s5_wrdata", 32'(bus.wrdata), 32'h78);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_output("s5_ready", 32'(bus.ready), 32'd1);
    check_output("s5_rdata", bus.rdata, 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      dn += int'(bus.done);
      @(negedge clk);
    end
    check_output("s5_done_count", 32'(dn), 32'd0);
    dval = {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]};
    check_output("s5_mem_word", dval, 32'hA5A5A578);

    // Scenario 6: top word address wraps into 0xFC..0xFF only.
    apply_stimulus(1'b0, 6'h3F, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("s6_adr", 32'(bus.adr), 32'hFC + 32'(k));
    end
    @(negedge clk);
    check_output("s6_done_adr", 32'(bus.adr), 32'h00);
    wait_idle();

    // Randomized traffic with occasional held req and mid-transfer reset.
    for (int t = 0; t < 80; t++) begin
      bit hold;
      logic [ADR_W-3:0] a;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = ($urandom_range(0, 1) == 0) ? (ADR_W-2)'($urandom_range(0, 7)) : (ADR_W-2)'($urandom);
      hold = ($urandom_range(0, 5) == 0);
      apply_stimulus(1'($urandom), a, $urandom, 4'($urandom), hold);
      if ($urandom_range(0, 11) == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end
      if (hold) begin
        repeat ($urandom_range(1, 7)) @(posedge clk);
        #1 bus.req = 1'b0;
      end
      wait_idle();
    end

    // Final memory image against the model.
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_output("mem_image_diffs", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
